spi_reg_ctrl: RTL

- Register-access sequencer that sits directly upstream of axis_spi_master.
- Converts single register read/write requests into a framed byte stream on the master's s_axis input, selects the target slave through the master's addr_i, and gathers the returned MISO bytes from the master's m_axis output into one response word.
- Keeps exactly one byte in flight at a time, so TX and RX stay aligned for the full-duplex SPI master.

---
 rtl/spi_reg_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - register read/write sequencer feeding a full-duplex AXIS SPI master
// Frames {rw, addr} plus REG_BYTES data bytes, one byte in flight, and collects the MISO bytes.
module spi_reg_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_BYTES  = 2,
    parameter int SLAVE_NUM  = 1,
    localparam int SW        = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
    localparam int RW        = REG_BYTES * DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rw_i,
    input  logic [DATA_WIDTH-2:0] req_addr_i,
    input  logic [RW-1:0]         req_wdata_i,
    input  logic [SW-1:0]         req_slave_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [RW-1:0]         rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [SW-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o
);
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    localparam logic [2:0] LAST = 3'(REG_BYTES);

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rw_q, rw_d;
    logic [RW-1:0]         wdata_q, wdata_d;
    logic [RW-1:0]         rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  err_q, err_d;
    logic [SW-1:0]         addr_q, addr_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [2:0]            cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        addr_d      = addr_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rw_d        = req_rw_i;
                    addr_d      = req_slave_i;
                    wdata_d     = req_wdata_i;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    tdata_d     = {req_rw_i, req_addr_i};
                    tvalid_d    = 1'b1;
                    cnt_d       = 3'd0;
                    req_ready_d = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // MISO data can only be legitimate once our byte has been handed over
                if (s_axis_tvalid_i) begin
                    err_d = 1'b1;
                end
                if (m_axis_tready_i) begin
                    tvalid_d = 1'b0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (s_axis_tvalid_i) begin
                    if (cnt_q != 3'd0) begin
                        rdata_d = (rdata_q << DATA_WIDTH) | RW'(s_axis_tdata_i);
                    end
                    if (cnt_q == LAST) begin
                        rsp_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        cnt_d    = cnt_q + 3'd1;
                        // wdata_q is consumed MSB-first by shifting it left after each byte
                        tdata_d  = rw_q ? '0 : wdata_q[RW-1 -: DATA_WIDTH];
                        wdata_d  = wdata_q << DATA_WIDTH;
                        tvalid_d = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            DONE: begin
                if (s_axis_tvalid_i) begin
                    err_d = 1'b1;
                end
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            cnt_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rdata_q;
    assign rsp_err_o       = err_q;
    assign addr_o          = addr_q;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign s_axis_tready_o = 1'b1;
endmodule
